// File: rtl/decoder_4to16_buf.sv
// Registered 4-to-16 one-hot decoder with a small output FIFO.
// Entries are decoded at push time; the FIFO head drives onehot_o.
module decoder_4to16_buf #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 2**IN_W,
    parameter int DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     valid_i,
    output logic                     ready_o,
    input  logic [IN_W-1:0]          idx_i,
    input  logic                     en_i,
    output logic                     valid_o,
    input  logic                     ready_i,
    output logic [OUT_W-1:0]         onehot_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Handshake: a beat transfers on a rising edge where valid and ready are
    // both high. ready_o depends only on held state; valid_o only on state.

    logic [OUT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [OUT_W-1:0] entry_d;
    logic             push;
    logic             pop;

    assign ready_o  = (count_q < CNT_W'(DEPTH));
    assign valid_o  = (count_q != '0);
    assign onehot_o = valid_o ? mem_q[rd_q] : '0;
    assign count_o  = count_q;

    assign push = valid_i & ready_o;
    assign pop  = valid_o & ready_i;

    always_comb begin
        entry_d = '0;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (en_i) begin
            entry_d = OUT_W'(1) << idx_i;
        end
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d = rd_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever empty.
    always_ff @(posedge clk_i) begin
        if (rst_ni && push) begin
            mem_q[wr_q] <= entry_d;
        end
    end

endmodule
